dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port controller in front of the byte-organized 32-byte data memory. Arbitrates word-wide load/store requests from two requesters: port 0 is the CPU MEM stage, port 1 is the testbench/debug loader. Each granted word access is sequenced as four single-byte memory beats in little-endian order, and the requester receives a one-cycle acknowledge. The block owns all sequencing, so the memory itself only sees clean per-byte read or write strobes.

## Interface
Parameters:
- MEM_BYTES, 32, memory size in bytes; power of two
- ADDR_W, 5, byte-address width driven to memory, log2(MEM_BYTES)

Ports:
- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  reset, asynchronous, active-low
- req0_i / req1_i  in  1  access request, port 0 / port 1
- we0_i / we1_i  in  1  1 = store word, 0 = load word
- addr0_i / addr1_i  in  32  byte address; only bits [ADDR_W-1:0] used
- wdata0_i / wdata1_i  in  32  store data
- ack0_o / ack1_o  out  1  one-cycle completion pulse
- rdata0_o / rdata1_o  out  32  load result, valid with ack and held afterwards
- busy_o  out  1  high in any state other than IDLE
- mem_addr_o  out  ADDR_W  byte address to memory
- mem_wdata_o  out  8  byte write data
- mem_we_o  out  1  byte write strobe
- mem_re_o  out  1  byte read strobe
- mem_rdata_i  in  8  byte read data; combinational from mem_addr_o

## Operation
- FSM states: IDLE, BEAT, DONE.
- IDLE: if any req is high, grant one port and latch its we, addr[ADDR_W-1:0] and wdata, clear beat counter k=0, then go to BEAT. With no request, stay in IDLE.
- BEAT, beat k = 0..3:
  - mem_addr_o = (base + k) mod MEM_BYTES. The address wraps, and misaligned bases are legal.
  - Store: mem_we_o=1, mem_wdata_o = wdata[8k+7:8k].
  - Load: mem_re_o=1; at the clock edge, capture mem_rdata_i into read buffer bits [8k+7:8k].
  - After k=3, go to DONE.
- DONE:
  - Pulse the granted ack for this cycle.
  - On a load, rdataN_o has the full word by this cycle.
  - Then go to IDLE.
- Outside BEAT, mem_we_o, mem_re_o, mem_addr_o and mem_wdata_o are all 0.
- rdataN_o updates only on a completed load on that port. A store never changes it.
- Request inputs are ignored while busy. Latched values are used, so inputs may change after the grant.
- A req that is still high in the IDLE cycle after DONE is a new transaction. The requester drops req in the cycle after it sees ack.
- Arbitration when both ports request in IDLE is set by the Configuration section.

## Timing
- Reset (asynchronous, active-low) values:
  - FSM = IDLE, k=0, busy_o=0, ack0_o=ack1_o=0.
  - rdata0_o=rdata1_o=0, all mem_* outputs 0, round-robin pointer = "last granted port 1".
- Latency: req sampled in IDLE at edge N → beats in cycles N+1..N+4 → ack in cycle N+5. Every transaction is 6 cycles IDLE-to-IDLE.
- Throughput: back-to-back requests from one port complete every 6 cycles.
- Reset mid-transaction aborts immediately with no ack. Bytes already written stay in memory. rdata outputs clear.
- An address of MEM_BYTES-2 touches bytes 30, 31, 0, 1.

## Configuration
- DMEM_ARB_RR_EN defined: round-robin arbitration. On a tie, the port not granted most recently wins. The pointer updates on every grant.
- DMEM_ARB_RR_EN undefined: fixed priority, port 0 always wins ties, and no pointer register exists.
- The setting has no other effect on timing.

## Test plan
- Reset: rst_i low mid-BEAT of a store → busy_o, ack, and mem_we_o drop asynchronously to 0, and FSM returns to IDLE.
- Store then load, port 0:
  - Store 0xDEADBEEF at 4 → memory bytes 4..7 = EF, BE, AD, DE; ack0_o rises 5 cycles after the request.
  - Load 4 → rdata0_o = 0xDEADBEEF when ack0_o pulses.
- Wrap: port 1 stores 0x11223344 at 30 → bytes 30=44, 31=33, 0=22, 1=11; load at 30 returns 0x11223344.
- Tie with DMEM_ARB_RR_EN: both ports request continuously → grants alternate 0, 1, 0, 1. Without the macro, port 0 is granted every time and port 1 starves until req0 drops.
- Input change while busy: port 0 changes addr/wdata during BEAT → the latched values are used, and the memory holds the originally requested data.
- Store isolation: port 1 load returns 0xCAFEF00D; a later port 1 store leaves rdata1_o at 0xCAFEF00D, and rdata0_o is unchanged throughout.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Purpose: two-port word load/store arbiter sequencing each access as four little-endian byte beats.
// Latency: request sampled in IDLE -> four beat cycles -> one-cycle ack; 6 cycles IDLE-to-IDLE.
// Backpressure: requests are ignored while busy; optional round-robin via DMEM_ARB_RR_EN (fixed priority otherwise).
module dmem_arbiter #(
    parameter int MEM_BYTES = 32,
    parameter int ADDR_W    = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req0_i,
    input  logic              req1_i,
    input  logic              we0_i,
    input  logic              we1_i,
    input  logic [31:0]       addr0_i,
    input  logic [31:0]       addr1_i,
    input  logic [31:0]       wdata0_i,
    input  logic [31:0]       wdata1_i,
    output logic              ack0_o,
    output logic              ack1_o,
    output logic [31:0]       rdata0_o,
    output logic [31:0]       rdata1_o,
    output logic              busy_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [7:0]        mem_wdata_o,
    output logic              mem_we_o,
    output logic              mem_re_o,
    input  logic [7:0]        mem_rdata_i
);

    typedef enum logic [1:0] {IDLE, BEAT, DONE} state_t;

    state_t              state_q, state_d;
    logic [1:0]          k_q, k_d;
    logic                gnt_q, gnt_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [31:0]         wdat_q, wdat_d;
    logic [23:0]         rbuf_q, rbuf_d;
    logic [31:0]         rdata0_q, rdata0_d;
    logic [31:0]         rdata1_q, rdata1_d;
    logic                ack0_q, ack0_d;
    logic                ack1_q, ack1_d;
    logic                busy_q, busy_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [7:0]          mem_wdata_q, mem_wdata_d;
    logic                mem_we_q, mem_we_d;
    logic                mem_re_q, mem_re_d;
    logic                pick;

`ifdef DMEM_ARB_RR_EN
    // Last granted port; reset value 1 lets port 0 win the first tie.
    logic                rr_q, rr_d;
`endif

    // Only the low address bits reach memory; the upper bits are dropped on purpose.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr0_i[31:ADDR_W], addr1_i[31:ADDR_W]};
    localparam int unused_mem_bytes = MEM_BYTES;

    // Port selection among active requesters: 0 = port 0, 1 = port 1.
    always_comb begin
`ifdef DMEM_ARB_RR_EN
        pick = (req0_i & req1_i) ? ~rr_q : req1_i;
`else
        pick = ~req0_i;
`endif
    end

    // Next-state, latching, read capture and registered memory-side outputs.
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        gnt_d       = gnt_q;
        we_d        = we_q;
        base_d      = base_q;
        wdat_d      = wdat_q;
        rbuf_d      = rbuf_q;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;
        ack0_d      = 1'b0;
        ack1_d      = 1'b0;
`ifdef DMEM_ARB_RR_EN
        rr_d        = rr_q;
`endif
        case (state_q)
            IDLE: begin
                if (req0_i | req1_i) begin
                    gnt_d   = pick;
                    we_d    = pick ? we1_i : we0_i;
                    base_d  = pick ? addr1_i[ADDR_W-1:0] : addr0_i[ADDR_W-1:0];
                    wdat_d  = pick ? wdata1_i : wdata0_i;
                    k_d     = 2'd0;
                    state_d = BEAT;
`ifdef DMEM_ARB_RR_EN
                    rr_d    = pick;
`endif
                end
            end
            BEAT: begin
                if (!we_q) begin
                    case (k_q)
                        2'd0:    rbuf_d[7:0]   = mem_rdata_i;
                        2'd1:    rbuf_d[15:8]  = mem_rdata_i;
                        2'd2:    rbuf_d[23:16] = mem_rdata_i;
                        default: rbuf_d        = rbuf_q;
                    endcase
                end
                if (k_q == 2'd3) begin
                    state_d = DONE;
                    ack0_d  = ~gnt_q;
                    ack1_d  = gnt_q;
                    // Final byte comes straight from memory so the word is ready with ack.
                    if (!we_q) begin
                        if (gnt_q) rdata1_d = {mem_rdata_i, rbuf_q};
                        else       rdata0_d = {mem_rdata_i, rbuf_q};
                    end
                end else begin
                    k_d = k_q + 2'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d      = (state_d != IDLE);
        mem_addr_d  = '0;
        mem_wdata_d = 8'h00;
        mem_we_d    = 1'b0;
        mem_re_d    = 1'b0;
        if (state_d == BEAT) begin
            // Natural overflow of the ADDR_W-bit sum gives the wrap-around.
            mem_addr_d = base_d + ADDR_W'(k_d);
            if (we_d) begin
                mem_we_d    = 1'b1;
                mem_wdata_d = wdat_d[{k_d, 3'b000} +: 8];
            end else begin
                mem_re_d    = 1'b1;
            end
        end
    end

    // State and registered outputs; reset aborts any transaction without ack.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            k_q         <= 2'd0;
            gnt_q       <= 1'b0;
            we_q        <= 1'b0;
            base_q      <= '0;
            wdat_q      <= 32'h0;
            rbuf_q      <= 24'h0;
            rdata0_q    <= 32'h0;
            rdata1_q    <= 32'h0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            busy_q      <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 8'h00;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
`ifdef DMEM_ARB_RR_EN
            rr_q        <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            gnt_q       <= gnt_d;
            we_q        <= we_d;
            base_q      <= base_d;
            wdat_q      <= wdat_d;
            rbuf_q      <= rbuf_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
            ack0_q      <= ack0_d;
            ack1_q      <= ack1_d;
            busy_q      <= busy_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            mem_re_q    <= mem_re_d;
`ifdef DMEM_ARB_RR_EN
            rr_q        <= rr_d;
`endif
        end
    end

    assign ack0_o      = ack0_q;
    assign ack1_o      = ack1_q;
    assign rdata0_o    = rdata0_q;
    assign rdata1_o    = rdata1_q;
    assign busy_o      = busy_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_we_o    = mem_we_q;
    assign mem_re_o    = mem_re_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: byte memory model plus word-level reference memory and per-port read results.
// Each transaction is checked beat by beat, on ack, and against the reference afterwards.
// Ties are checked against the arbitration rule selected by DMEM_ARB_RR_EN.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, req1, we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        ack0, ack1, busy;
    logic [31:0] rdata0, rdata1;
    logic [4:0]  mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;
    logic        mem_we, mem_re;

    int checks = 0;
    int passes = 0;

    logic [7:0]  mem [32];
    logic [7:0]  ref_mem [32];
    logic [31:0] ref_rd [2];

    always #5 clk = ~clk;

    dmem_arbiter #(.MEM_BYTES(32), .ADDR_W(5)) dut (
        .clk_i(clk), .rst_i(rst_n),
        .req0_i(req0), .req1_i(req1), .we0_i(we0), .we1_i(we1),
        .addr0_i(addr0), .addr1_i(addr1), .wdata0_i(wdata0), .wdata1_i(wdata1),
        .ack0_o(ack0), .ack1_o(ack1), .rdata0_o(rdata0), .rdata1_o(rdata1),
        .busy_o(busy), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_we_o(mem_we), .mem_re_o(mem_re), .mem_rdata_i(mem_rdata)
    );

    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

    function automatic logic [31:0] ref_word(input logic [4:0] b);
        return {ref_mem[5'(b + 5'd3)], ref_mem[5'(b + 5'd2)], ref_mem[5'(b + 5'd1)], ref_mem[b]};
    endfunction

    task automatic drive(input int p, input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        if (p == 0) begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
        else        begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
    endtask

    // One word access on port p, checked beat by beat and against the reference.
    task automatic do_txn(input int p, input logic w, input logic [31:0] a, input logic [31:0] d, input bit scramble);
        logic [4:0]  base;
        logic [4:0]  ea;
        logic [31:0] other;
        logic [31:0] got_rd;
        bit          got;
        base  = a[4:0];
        other = ref_rd[1-p];
        @(negedge clk);
        drive(p, 1'b1, w, a, d);
        got = 0;
        for (int c = 1; c <= 8 && !got; c++) begin
            @(posedge clk); #1;
            if (c <= 4) begin
                ea = 5'(base + 5'(c - 1));
                checks++;
                if (mem_addr !== ea || mem_we !== w || mem_re !== !w || busy !== 1'b1) begin
                    $display("FAIL beat%0d port%0d: addr=%0d we=%b re=%b busy=%b, want addr=%0d we=%b re=%b busy=1",
                             c - 1, p, mem_addr, mem_we, mem_re, busy, ea, w, !w);
                end else passes++;
                if (w) begin
                    checks++;
                    if (mem_wdata !== d[8*(c-1) +: 8])
                        $display("FAIL beat%0d_wdata: got %h want %h", c - 1, mem_wdata, d[8*(c-1) +: 8]);
                    else passes++;
                end
                if (scramble) drive(p, 1'b1, $urandom, $urandom, $urandom);
            end
            if ((p == 0 ? ack1 : ack0) === 1'b1) begin
                checks++;
                $display("FAIL wrong_port_ack: port %0d acked while port %0d granted", 1 - p, p);
            end
            if ((p == 0 ? ack0 : ack1) === 1'b1) begin
                got = 1;
                drive(p, 1'b0, 1'b0, 32'h0, 32'h0);
                checks++;
                if (c != 5) $display("FAIL ack_latency: ack after %0d edges, want 5", c);
                else passes++;
                checks++;
                if (mem_we !== 1'b0 || mem_re !== 1'b0 || mem_addr !== 5'd0 || mem_wdata !== 8'h00)
                    $display("FAIL done_mem_idle: we=%b re=%b addr=%0d wdata=%h, want all 0", mem_we, mem_re, mem_addr, mem_wdata);
                else passes++;
                if (w) for (int k = 0; k < 4; k++) ref_mem[5'(base + 5'(k))] = d[8*k +: 8];
                else   ref_rd[p] = ref_word(base);
                got_rd = (p == 0) ? rdata0 : rdata1;
                checks++;
                if (got_rd !== ref_rd[p]) $display("FAIL rdata%0d_on_ack: got %h want %h", p, got_rd, ref_rd[p]);
                else passes++;
                got_rd = (p == 0) ? rdata1 : rdata0;
                checks++;
                if (got_rd !== other) $display("FAIL rdata%0d_isolation: got %h want %h", 1 - p, got_rd, other);
                else passes++;
            end
        end
        if (!got) begin
            checks++;
            $display("FAIL ack_timeout: port %0d no ack within 8 cycles", p);
            drive(p, 1'b0, 1'b0, 32'h0, 32'h0);
        end
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || ack0 !== 1'b0 || ack1 !== 1'b0)
            $display("FAIL back_to_idle: busy=%b ack0=%b ack1=%b, want 0 0 0", busy, ack0, ack1);
        else passes++;
        for (int k = 0; k < 4; k++) begin
            ea = 5'(base + 5'(k));
            checks++;
            if (mem[ea] !== ref_mem[ea]) $display("FAIL mem_byte[%0d]: got %h want %h", ea, mem[ea], ref_mem[ea]);
            else passes++;
        end
    endtask

    task automatic test_reset;
        checks++;
        if (busy !== 0 || ack0 !== 0 || ack1 !== 0 || rdata0 !== 0 || rdata1 !== 0 ||
            mem_we !== 0 || mem_re !== 0 || mem_addr !== 0 || mem_wdata !== 0)
            $display("FAIL reset_values: busy=%b ack=%b%b rd0=%h rd1=%h we=%b re=%b addr=%0d wd=%h, want all 0",
                     busy, ack0, ack1, rdata0, rdata1, mem_we, mem_re, mem_addr, mem_wdata);
        else passes++;
    endtask

    task automatic test_store_load;
        logic [31:0] exp_w;
        logic [7:0]  exp_b [4];
        exp_w = 32'hDEADBEEF;
        exp_b = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        do_txn(0, 1'b1, 32'd4, exp_w, 0);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (mem[4+k] !== exp_b[k]) $display("FAIL store_byte%0d: got %h want %h", 4 + k, mem[4+k], exp_b[k]);
            else passes++;
        end
        do_txn(0, 1'b0, 32'd4, 32'h0, 0);
        checks++;
        if (rdata0 !== exp_w) $display("FAIL load_deadbeef: got %h want %h", rdata0, exp_w);
        else passes++;
    endtask

    task automatic test_wrap;
        logic [31:0] exp_w;
        exp_w = 32'h11223344;
        do_txn(1, 1'b1, 32'd30, exp_w, 0);
        checks++;
        if (mem[30] !== 8'h44 || mem[31] !== 8'h33 || mem[0] !== 8'h22 || mem[1] !== 8'h11)
            $display("FAIL wrap_bytes: got %h %h %h %h want 44 33 22 11", mem[30], mem[31], mem[0], mem[1]);
        else passes++;
        do_txn(1, 1'b0, 32'hFFFF_FFFE, 32'h0, 0);
        checks++;
        if (rdata1 !== exp_w) $display("FAIL wrap_load: got %h want %h", rdata1, exp_w);
        else passes++;
    endtask

    task automatic test_busy_change;
        logic [31:0] exp_w;
        exp_w = 32'hA5C3_5A3C;
        do_txn(0, 1'b1, 32'd8, exp_w, 1);
        checks++;
        if ({mem[11], mem[10], mem[9], mem[8]} !== exp_w)
            $display("FAIL busy_latched: got %h want %h", {mem[11], mem[10], mem[9], mem[8]}, exp_w);
        else passes++;
    endtask

    task automatic test_store_isolation;
        logic [31:0] rd0;
        do_txn(0, 1'b1, 32'd12, 32'hCAFEF00D, 0);
        rd0 = ref_rd[0];
        do_txn(1, 1'b0, 32'd12, 32'h0, 0);
        checks++;
        if (rdata1 !== 32'hCAFEF00D) $display("FAIL iso_load: got %h want cafef00d", rdata1);
        else passes++;
        do_txn(1, 1'b1, 32'd16, 32'h12345678, 0);
        checks++;
        if (rdata1 !== 32'hCAFEF00D || rdata0 !== rd0)
            $display("FAIL iso_store: rd1=%h rd0=%h want cafef00d %h", rdata1, rdata0, rd0);
        else passes++;
    endtask

    // Both ports hold loads; after four grants port 0 drops and port 1 must follow.
    task automatic test_tie;
        int   last;
        int   want;
        int   who;
        bit   got;
        logic [31:0] got_rd;
        last = 1;
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 32'd4, 32'h0);
        drive(1, 1'b1, 1'b0, 32'd30, 32'h0);
        for (int i = 0; i < 5; i++) begin
`ifdef DMEM_ARB_RR_EN
            want = (i == 4) ? 1 : 1 - last;
`else
            want = (i == 4) ? 1 : 0;
`endif
            last = want;
            got = 0;
            who = 0;
            for (int c = 0; c < 10 && !got; c++) begin
                @(posedge clk); #1;
                if (ack0 === 1'b1 || ack1 === 1'b1) begin
                    got = 1;
                    who = (ack1 === 1'b1) ? 1 : 0;
                end
            end
            checks++;
            if (!got) $display("FAIL tie_timeout: grant %0d no ack", i);
            else if (who != want || (ack0 === 1'b1 && ack1 === 1'b1))
                $display("FAIL tie_grant%0d: acked port %0d want %0d", i, who, want);
            else passes++;
            if (got) begin
                ref_rd[who] = ref_word(who == 0 ? 5'd4 : 5'd30);
                got_rd = (who == 0) ? rdata0 : rdata1;
                checks++;
                if (got_rd !== ref_rd[who]) $display("FAIL tie_rdata%0d: got %h want %h", who, got_rd, ref_rd[who]);
                else passes++;
            end
            if (i == 3) drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
            if (i == 4) drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        end
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
    endtask

    task automatic test_random;
        for (int i = 0; i < 30; i++)
            do_txn(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom, bit'($urandom_range(0, 1)));
    endtask

    task automatic test_reset_mid;
        logic [31:0] d;
        d = 32'h8899_AABB;
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 32'd20, d);
        @(posedge clk); #1;
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 0 || ack0 !== 0 || mem_we !== 0 || mem_addr !== 0 || rdata0 !== 0 || rdata1 !== 0)
            $display("FAIL reset_mid: busy=%b ack0=%b we=%b addr=%0d rd0=%h rd1=%h, want all 0",
                     busy, ack0, mem_we, mem_addr, rdata0, rdata1);
        else passes++;
        ref_mem[20] = d[7:0];
        ref_rd[0]   = 32'h0;
        ref_rd[1]   = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 20; k < 24; k++) begin
            checks++;
            if (mem[k] !== ref_mem[k]) $display("FAIL reset_mid_mem[%0d]: got %h want %h", k, mem[k], ref_mem[k]);
            else passes++;
        end
        do_txn(1, 1'b0, 32'd20, 32'h0, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 32; i++) begin
            mem[i]     <= 8'(i * 37 + 5);
            ref_mem[i]  = 8'(i * 37 + 5);
        end
        ref_rd[0] = 32'h0;
        ref_rd[1] = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        test_reset;
        @(negedge clk);
        rst_n = 1'b1;
        test_store_load;
        test_wrap;
        test_busy_change;
        test_store_isolation;
        test_tie;
        test_random;
        test_reset_mid;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
